// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// The optional statistics counters are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        PRI_A  = 2'd0,
        PRI_B  = 2'd1,
        LOCK_B = 2'd2
    } arb_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_A    = 2'd1;
    localparam logic [1:0] OWN_B    = 2'd2;

    function automatic logic f3_valid(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// Priority state, burst counter and combinational grant decision.
module dmem_arb_fsm
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_req,
    input  logic b_req,
    input  logic b_lock,
    output logic a_gnt,
    output logic b_gnt
);

    localparam logic [7:0] MAXB = 8'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        unique case (state_q)
            PRI_B: begin
                b_gnt = b_req;
                a_gnt = a_req & ~b_req;
                if (b_gnt) begin
                    if (b_lock) begin
                        state_d = LOCK_B;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = PRI_A;
                    end
                end
            end
            LOCK_B: begin
                if (b_req && b_lock && (cnt_q < MAXB)) begin
                    b_gnt = 1'b1;
                    // only beats that actually hold A off count toward the limit
                    if (a_req && (cnt_q != 8'hFF)) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    a_gnt   = a_req;
                    b_gnt   = b_req & ~a_req;
                    state_d = PRI_A;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                a_gnt = a_req;
                b_gnt = b_req & ~a_req;
                if (a_gnt && b_req) begin
                    state_d = PRI_B;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PRI_A;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Define DMEM_ARB_STATS_EN to add conflict/stall counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_wdata,
    input  logic [2:0]        a_funct3,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [WIDTH-1:0]  a_rdata,
    output logic              stall,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_wdata,
    input  logic [2:0]        b_funct3,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [WIDTH-1:0]  b_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_read,
    output logic              m_write,
    output logic [WIDTH-1:0]  m_wdata,
    output logic [2:0]        m_funct3,
    input  logic [WIDTH-1:0]  m_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       a_stall_cnt
`endif
);

    logic [1:0] owner_q, owner_d;

    dmem_arb_fsm #(
        .MAX_BURST(MAX_BURST)
    ) u_fsm (
        .clk   (clk),
        .rst_n (rst_n),
        .a_req (a_req),
        .b_req (b_req),
        .b_lock(b_lock),
        .a_gnt (a_gnt),
        .b_gnt (b_gnt)
    );

    assign stall = a_req & ~a_gnt;

    always_comb begin
        m_addr   = '0;
        m_read   = 1'b0;
        m_write  = 1'b0;
        m_wdata  = '0;
        m_funct3 = 3'b000;
        owner_d  = OWN_NONE;
        if (a_gnt) begin
            m_addr   = a_addr;
            m_read   = ~a_we;
            m_write  = a_we;
            m_wdata  = a_wdata;
            m_funct3 = a_funct3;
            owner_d  = a_we ? OWN_NONE : OWN_A;
        end else if (b_gnt) begin
            m_addr   = b_addr;
            m_read   = ~b_we;
            m_write  = b_we;
            m_wdata  = b_wdata;
            m_funct3 = b_funct3;
            owner_d  = b_we ? OWN_NONE : OWN_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign a_rvalid = (owner_q == OWN_A);
    assign b_rvalid = (owner_q == OWN_B);
    assign a_rdata  = a_rvalid ? m_rdata : '0;
    assign b_rdata  = b_rvalid ? m_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        conflict_d = conflict_q;
        stall_d    = stall_q;
        if (stats_clr) begin
            conflict_d = 16'd0;
            stall_d    = 16'd0;
        end else begin
            if (a_req && b_req && (conflict_q != 16'hFFFF)) begin
                conflict_d = conflict_q + 16'd1;
            end
            if (stall && (stall_q != 16'hFFFF)) begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 16'd0;
            stall_q    <= 16'd0;
        end else begin
            conflict_q <= conflict_d;
            stall_q    <= stall_d;
        end
    end

    assign conflict_cnt = conflict_q;
    assign a_stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 64-word memory.
// Stats checks run when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req, a_we, b_req, b_we, b_lock;
    logic [5:0]  a_addr, b_addr, m_addr;
    logic [31:0] a_wdata, b_wdata, m_wdata, m_rdata;
    logic [2:0]  a_funct3, b_funct3, m_funct3;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, stall;
    logic        m_read, m_write;
    logic [31:0] a_rdata, b_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] conflict_cnt, a_stall_cnt;
`endif

    typedef struct {
        bit          port_b;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [64];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(6), .WIDTH(32), .MAX_BURST(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_funct3(a_funct3),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .stall(stall),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_funct3(b_funct3), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .m_addr(m_addr), .m_read(m_read), .m_write(m_write),
        .m_wdata(m_wdata), .m_funct3(m_funct3), .m_rdata(m_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stats_clr(stats_clr), .conflict_cnt(conflict_cnt),
        .a_stall_cnt(a_stall_cnt)
`endif
    );

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        m_rdata = 32'd0;
    end

    always @(posedge clk) begin
        if (m_write) mem[m_addr] <= m_wdata;
        if (m_read) m_rdata <= f3_valid(m_funct3) ? mem[m_addr] : 32'd0;
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_rvalid || b_rvalid) begin
            if (sb.size() == 0) begin
                chk("rvalid_spurious", {30'd0, a_rvalid, b_rvalid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rv_port", {30'd0, a_rvalid, b_rvalid},
                    mon_e.port_b ? 32'd1 : 32'd2);
                chk("rdata", mon_e.port_b ? b_rdata : a_rdata, mon_e.data);
                chk("rdata_other", mon_e.port_b ? a_rdata : b_rdata, 32'd0);
            end
        end
    end

    task automatic idle();
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_funct3 = F3_W;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_funct3 = F3_W;
        b_lock = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit pb, input logic [31:0] d);
        exp_t e;
        e.port_b = pb;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic gnt_chk(input string n, input bit ea, input bit eb);
        chk({n, "_agnt"}, {31'd0, a_gnt}, {31'd0, ea});
        chk({n, "_bgnt"}, {31'd0, b_gnt}, {31'd0, eb});
        chk({n, "_stall"}, {31'd0, stall}, {31'd0, a_req & ~ea});
    endtask

    task automatic a_acc(input bit we, input logic [5:0] ad,
                         input logic [31:0] d);
        idle();
        a_req = 1; a_we = we; a_addr = ad; a_wdata = d;
    endtask

    bit alt_a [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        idle();
        @(negedge clk);
        chk("rst_arv", {31'd0, a_rvalid}, 32'd0);
        chk("rst_brv", {31'd0, b_rvalid}, 32'd0);
        chk("rst_ard", a_rdata, 32'd0);
        chk("rst_brd", b_rdata, 32'd0);
        chk("idle_maddr", {26'd0, m_addr}, 32'd0);
        chk("idle_mwdata", m_wdata, 32'd0);
        next();
        rst_n = 1;

        a_acc(1, 6'd5, 32'hDEADBEEF);
        @(negedge clk);
        gnt_chk("sw5", 1, 0);
        chk("sw5_mw", {31'd0, m_write}, 32'd1);
        chk("sw5_mr", {31'd0, m_read}, 32'd0);
        chk("sw5_addr", {26'd0, m_addr}, 32'd5);
        chk("sw5_wd", m_wdata, 32'hDEADBEEF);
        next();
        a_acc(0, 6'd5, 32'd0);
        @(negedge clk);
        gnt_chk("lw5", 1, 0);
        chk("lw5_mr", {31'd0, m_read}, 32'd1);
        chk("lw5_mw", {31'd0, m_write}, 32'd0);
        push(0, 32'hDEADBEEF);
        next();
        a_acc(1, 6'd3, 32'h33333333);
        next();
        a_acc(1, 6'd4, 32'h44444444);
        next();

        for (int i = 0; i < 4; i++) begin
            idle();
            a_req = 1; a_addr = 6'd5;
            b_req = 1; b_addr = 6'd3;
            @(negedge clk);
            gnt_chk("alt", alt_a[i], !alt_a[i]);
            chk("alt_maddr", {26'd0, m_addr}, alt_a[i] ? 32'd5 : 32'd3);
            push(!alt_a[i], alt_a[i] ? 32'hDEADBEEF : 32'h33333333);
            next();
        end

        idle();
        b_req = 1; b_addr = 6'd3;
        @(negedge clk);
        gnt_chk("xb", 0, 1);
        push(1, 32'h33333333);
        next();
        a_acc(0, 6'd4, 32'd0);
        @(negedge clk);
        gnt_chk("xa", 1, 0);
        push(0, 32'h44444444);
        next();

        for (int i = 0; i < 10; i++) begin
            idle();
            a_req = 1; a_addr = 6'd4;
            b_req = 1; b_we = 1; b_lock = 1;
            b_addr = 6'(20 + i); b_wdata = 32'(i);
            @(negedge clk);
            gnt_chk("lock", (i == 0) || (i == 9), (i != 0) && (i != 9));
            if (a_gnt) push(0, 32'h44444444);
            next();
        end

        a_acc(0, 6'd5, 32'd0);
        a_funct3 = 3'b011;
        @(negedge clk);
        gnt_chk("badf3", 1, 0);
        chk("badf3_f3", {29'd0, m_funct3}, 32'd3);
        push(0, 32'd0);
        next();

        a_acc(0, 6'd5, 32'd0);
        @(negedge clk);
        gnt_chk("rstrd", 1, 0);
        next();
        chk("inflight_rv", {31'd0, a_rvalid}, 32'd1);
        rst_n = 0;
        idle();
        #1;
        chk("rst_drop_rv", {31'd0, a_rvalid}, 32'd0);
        chk("rst_drop_rd", a_rdata, 32'd0);
        next();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rv", {30'd0, a_rvalid, b_rvalid}, 32'd0);
            next();
        end
        idle();
        a_req = 1; a_we = 1; a_addr = 6'd30;
        b_req = 1; b_we = 1; b_addr = 6'd31;
        @(negedge clk);
        gnt_chk("post_rst_pri", 1, 0);
        next();

`ifdef DMEM_ARB_STATS_EN
        idle();
        stats_clr = 1;
        next();
        stats_clr = 0;
        for (int i = 0; i < 10; i++) begin
            idle();
            a_req = 1; a_we = 1; a_addr = 6'd40;
            b_req = 1; b_we = 1; b_addr = 6'd41;
            next();
        end
        idle();
        stats_clr = 1;
        @(negedge clk);
        chk("conflict_pre", {16'd0, conflict_cnt}, 32'd10);
        chk("stall_pre", {16'd0, a_stall_cnt}, 32'd5);
        next();
        stats_clr = 0;
        @(negedge clk);
        chk("conflict_clr", {16'd0, conflict_cnt}, 32'd0);
        chk("stall_clr", {16'd0, a_stall_cnt}, 32'd0);
        next();
`endif

        idle();
        repeat (3) next();
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
